// File: rtl/mdio_pkg.sv
// Shared constants and FSM state type for the Clause-22 MDIO peripheral.
package mdio_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] TA_WRITE = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_WDATA,
        S_RDATA,
        S_COMMIT
    } mdio_state_e;
endpackage

// File: rtl/mdc_edge_detect.sv
// Synchronises MDC into the clk domain and emits registered one-clk rise/fall pulses.
module mdc_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic mdc,
    output logic rise,
    output logic fall
);
    logic [2:0] sync_q, sync_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[1:0], mdc};
        rise_d = sync_q[1] & ~sync_q[2];
        fall_d = ~sync_q[1] & sync_q[2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/mdio_peripheral.sv
// Clause-22 MDIO management slave: frame decoder, register file, read shifter,
// write-commit strobe and saturating aborted-frame counter.
module mdio_peripheral
    import mdio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PHY_ADDR = 5'd1,
    parameter int                NUM_REGS = 32,
    parameter int                PRE_BITS = 32,
    parameter int                ERR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mdc,
    input  logic              mdio_out,
    input  logic              mdio_oe,
    output logic              mdio_in,
    output logic              mdio_in_oe,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [ERR_W-1:0]  err_cnt
);
    localparam logic [5:0] NUM_REGS_L = 6'(NUM_REGS);
    localparam logic [5:0] PRE_L      = 6'(PRE_BITS);

    logic              rise, fall;
    mdio_state_e       state_q, state_d;
    logic [5:0]        pre_q, pre_d;
    logic [3:0]        bit_q, bit_d;
    logic [4:0]        rd_q, rd_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              mdio_in_q, mdio_in_d;
    logic              oe_q, oe_d;
    logic              strobe_q, strobe_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];
    logic              abort;

    function automatic logic addr_impl(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NUM_REGS_L;
    endfunction

    mdc_edge_detect u_edge (
        .clk  (clk),
        .rst  (reset),
        .mdc  (mdc),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        bit_d     = bit_q;
        rd_d      = rd_q;
        op_d      = op_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        mdio_in_d = mdio_in_q;
        oe_d      = oe_q;
        strobe_d  = 1'b0;
        wa_d      = wa_q;
        wd_d      = wd_q;
        err_d     = err_q;
        abort     = 1'b0;

        case (state_q)
            S_IDLE: if (rise) begin
                if (mdio_out) begin
                    if (pre_q != PRE_L) pre_d = pre_q + 6'd1;
                end else begin
                    if (pre_q == PRE_L) state_d = S_START;
                    pre_d = '0;
                end
            end
            S_START: if (rise) begin
                if (!mdio_oe || mdio_out != ST[0]) begin
                    abort = 1'b1;
                end else begin
                    state_d = S_OP;
                    bit_d   = '0;
                end
            end
            S_OP: if (rise) begin
                if (!mdio_oe) begin
                    abort = 1'b1;
                end else begin
                    op_d  = {op_q[0], mdio_out};
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd1) begin
                        bit_d = '0;
                        if (op_d == OP_WRITE || op_d == OP_READ) state_d = S_PHYAD;
                        else abort = 1'b1;
                    end
                end
            end
            S_PHYAD: if (rise) begin
                if (!mdio_oe) begin
                    abort = 1'b1;
                end else begin
                    addr_d = {addr_q[ADDR_W-2:0], mdio_out};
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == 4'd4) begin
                        bit_d = '0;
                        // Another PHY's frame is not an error: just wait for the next preamble.
                        if (addr_d == PHY_ADDR) begin
                            state_d = S_REGAD;
                        end else begin
                            state_d = S_IDLE;
                            pre_d   = '0;
                        end
                    end
                end
            end
            S_REGAD: if (rise) begin
                if (!mdio_oe) begin
                    abort = 1'b1;
                end else begin
                    addr_d = {addr_q[ADDR_W-2:0], mdio_out};
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == 4'd4) begin
                        bit_d = '0;
                        if (op_q == OP_READ) begin
                            shift_d = addr_impl(addr_d) ? regs_q[addr_d] : '1;
                            rd_d    = '0;
                            state_d = S_RDATA;
                        end else begin
                            state_d = S_TA;
                        end
                    end
                end
            end
            S_TA: if (rise) begin
                if (!mdio_oe || mdio_out != ((bit_q == 4'd0) ? TA_WRITE[1] : TA_WRITE[0])) begin
                    abort = 1'b1;
                end else if (bit_q == 4'd1) begin
                    state_d = S_WDATA;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_WDATA: if (rise) begin
                if (!mdio_oe) begin
                    abort = 1'b1;
                end else begin
                    shift_d = {shift_q[DATA_W-2:0], mdio_out};
                    if (bit_q == 4'd15) begin
                        state_d = S_COMMIT;
                        // Strobe and wr_* are registered on COMMIT entry; the array follows from them.
                        if (addr_impl(addr_q)) begin
                            strobe_d = 1'b1;
                            wa_d     = addr_q;
                            wd_d     = shift_d;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                pre_d   = '0;
            end
            S_RDATA: if (fall) begin
                rd_d = rd_q + 5'd1;
                if (rd_d == 5'd2) begin
                    oe_d      = 1'b1;
                    mdio_in_d = 1'b0;
                end else if (rd_d >= 5'd3 && rd_d <= 5'd18) begin
                    mdio_in_d = shift_q[DATA_W-1];
                    shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                end else if (rd_d == 5'd19) begin
                    oe_d      = 1'b0;
                    mdio_in_d = 1'b1;
                    state_d   = S_IDLE;
                    pre_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            pre_d   = '0;
            if (err_q != '1) err_d = err_q + ERR_W'(1);
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (state_q == S_COMMIT && strobe_q) regs_d[wa_q] = wd_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            bit_q     <= '0;
            rd_q      <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            shift_q   <= '0;
            mdio_in_q <= 1'b1;
            oe_q      <= 1'b0;
            strobe_q  <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            err_q     <= '0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            bit_q     <= bit_d;
            rd_q      <= rd_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            shift_q   <= shift_d;
            mdio_in_q <= mdio_in_d;
            oe_q      <= oe_d;
            strobe_q  <= strobe_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            regs_q    <= regs_d;
        end
    end

    assign mdio_in    = mdio_in_q;
    assign mdio_in_oe = oe_q;
    assign wr_strobe  = strobe_q;
    assign wr_addr    = wa_q;
    assign wr_data    = wd_q;
    assign busy       = (state_q != S_IDLE);
    assign err_cnt    = err_q;
endmodule

// File: tb/tb_mdio_peripheral.sv
// Bench for mdio_peripheral: acts as the MDIO controller, checks frames against
// a directed table, a register-file model under random traffic, and corner sequences.
module tb_mdio_peripheral;
    import mdio_pkg::*;

    localparam int NREGS = 16;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        mdc, mdio_out, mdio_oe;
    logic        mdio_in, mdio_in_oe, wr_strobe, busy;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  err_cnt;
    logic        d2_in, d2_in_oe, d2_strobe, d2_busy;
    logic [4:0]  d2_addr;
    logic [15:0] d2_data;
    logic [7:0]  d2_err;

    always #5 clk = ~clk;

    mdio_peripheral #(.PHY_ADDR(5'd1), .NUM_REGS(NREGS), .PRE_BITS(32), .ERR_W(8)) dut (
        .clk(clk), .reset(rst), .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe),
        .mdio_in(mdio_in), .mdio_in_oe(mdio_in_oe), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .err_cnt(err_cnt)
    );

    // Short-preamble instance used only to reach error-counter saturation quickly.
    mdio_peripheral #(.PHY_ADDR(5'd1), .NUM_REGS(4), .PRE_BITS(1), .ERR_W(8)) dut2 (
        .clk(clk), .reset(rst2), .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe),
        .mdio_in(d2_in), .mdio_in_oe(d2_in_oe), .wr_strobe(d2_strobe),
        .wr_addr(d2_addr), .wr_data(d2_data), .busy(d2_busy), .err_cnt(d2_err)
    );

    int errors = 0;
    int checks = 0;

    int          strobe_cnt  = 0;
    int          strobe_wide = 0;
    logic        strobe_prev = 1'b0;
    logic [4:0]  mon_addr = '0;
    logic [15:0] mon_data = '0;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            mon_addr = wr_addr;
            mon_data = wr_data;
            if (strobe_prev) strobe_wide++;
        end
        strobe_prev = (wr_strobe === 1'b1);
    end

    logic [31:0] smp_in, smp_oe;

    logic [15:0] mregs [32];
    logic [7:0]  merr;
    logic [4:0]  mwa;
    logic [15:0] mwd;

    typedef struct {
        int          pre;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [1:0]  ta;
        logic [15:0] wd;
        bit          exp_strobe;
        bit          exp_drive;
        logic [15:0] exp_rd;
        logic [7:0]  exp_err;
        logic [4:0]  exp_wa;
        logic [15:0] exp_wd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic mdio_bit(input logic oe, input logic d, input int k, input bit do_rst);
        mdc = 1'b0;
        mdio_oe = oe;
        mdio_out = d;
        #40;
        if (do_rst) begin
            chk("pre_reset_oe", {31'b0, mdio_in_oe}, 32'd1);
            rst = 1'b1;
            #1;
            chk("rst_oe", {31'b0, mdio_in_oe}, 32'd0);
            chk("rst_in", {31'b0, mdio_in}, 32'd1);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_err", {24'b0, err_cnt}, 32'd0);
            chk("rst_wr", {11'b0, wr_addr, wr_data}, 32'd0);
            #8;
            rst = 1'b0;
            #1;
        end else begin
            #10;
        end
        mdc = 1'b1;
        if (k >= 0 && k < 32) begin
            smp_in[k] = mdio_in;
            smp_oe[k] = mdio_in_oe;
        end
        #50;
    endtask

    task automatic run_frame(input int pre, input logic [31:0] bd, input logic [31:0] boe,
                             input int rst_at);
        smp_in = '0;
        smp_oe = '0;
        for (int i = 0; i < pre; i++) mdio_bit(1'b1, 1'b1, -1, 1'b0);
        for (int k = 0; k < 32; k++) mdio_bit(boe[31-k], bd[31-k], k, k == rst_at);
        // Trailing 0 completes the read release and clears any preamble count.
        mdio_bit(1'b1, 1'b0, -1, 1'b0);
        #100;
    endtask

    function automatic logic [31:0] mk_body(input logic [1:0] op, input logic [4:0] phy,
                                            input logic [4:0] ra, input logic [1:0] ta,
                                            input logic [15:0] wd);
        if (op == OP_READ) return {ST, op, phy, ra, 18'h3FFFF};
        return {ST, op, phy, ra, ta, wd};
    endfunction

    function automatic logic [31:0] mk_oe(input logic [1:0] op);
        return (op == OP_READ) ? 32'hFFFC_0000 : 32'hFFFF_FFFF;
    endfunction

    task automatic check_frame(input string tag, input int sc0, input bit exp_strobe,
                               input bit exp_drive, input logic [15:0] exp_rd,
                               input logic [7:0] exp_err, input logic [4:0] ewa,
                               input logic [15:0] ewd);
        logic [15:0] rd;
        logic        shape;
        for (int j = 0; j < 16; j++) rd[15-j] = smp_in[16+j];
        shape = (smp_oe[13:0] == 14'd0) && !smp_oe[14] && smp_oe[15] && !smp_in[15]
                && (&smp_oe[31:16]);
        chk($sformatf("%s.strobes", tag), strobe_cnt - sc0, exp_strobe ? 32'd1 : 32'd0);
        if (exp_strobe) chk($sformatf("%s.strobe_val", tag), {11'b0, mon_addr, mon_data},
                            {11'b0, ewa, ewd});
        chk($sformatf("%s.wr_hold", tag), {11'b0, wr_addr, wr_data}, {11'b0, ewa, ewd});
        if (exp_drive) begin
            chk($sformatf("%s.rd_shape", tag), {31'b0, shape}, 32'd1);
            chk($sformatf("%s.rd_data", tag), {16'b0, rd}, {16'b0, exp_rd});
        end else begin
            chk($sformatf("%s.no_drive", tag), smp_oe, 32'd0);
        end
        chk($sformatf("%s.err", tag), {24'b0, err_cnt}, {24'b0, exp_err});
        chk($sformatf("%s.idle", tag), {29'b0, busy, mdio_in_oe, mdio_in}, 32'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sc0;
        logic [1:0]  op;
        logic [4:0]  phy, ra;
        logic [15:0] wd, erd;
        bit          es, ed;
        logic [31:0] bd, boe;

        vecs[0]  = '{32, OP_WRITE, 5'd1, 5'd4,  2'b10, 16'hA5C3, 1, 0, 16'h0000, 8'd0, 5'd4, 16'hA5C3};
        vecs[1]  = '{32, OP_READ,  5'd1, 5'd4,  2'b10, 16'h0000, 0, 1, 16'hA5C3, 8'd0, 5'd4, 16'hA5C3};
        vecs[2]  = '{32, OP_READ,  5'd1, 5'd31, 2'b10, 16'h0000, 0, 1, 16'hFFFF, 8'd0, 5'd4, 16'hA5C3};
        vecs[3]  = '{32, OP_WRITE, 5'd1, 5'd20, 2'b10, 16'h1234, 0, 0, 16'h0000, 8'd0, 5'd4, 16'hA5C3};
        vecs[4]  = '{32, OP_WRITE, 5'd2, 5'd4,  2'b10, 16'h0000, 0, 0, 16'h0000, 8'd0, 5'd4, 16'hA5C3};
        vecs[5]  = '{32, OP_READ,  5'd2, 5'd4,  2'b10, 16'h0000, 0, 0, 16'h0000, 8'd0, 5'd4, 16'hA5C3};
        vecs[6]  = '{32, OP_READ,  5'd1, 5'd4,  2'b10, 16'h0000, 0, 1, 16'hA5C3, 8'd0, 5'd4, 16'hA5C3};
        vecs[7]  = '{31, OP_WRITE, 5'd1, 5'd5,  2'b10, 16'hBEEF, 0, 0, 16'h0000, 8'd0, 5'd4, 16'hA5C3};
        vecs[8]  = '{32, 2'b11,    5'd1, 5'd4,  2'b10, 16'h0000, 0, 0, 16'h0000, 8'd1, 5'd4, 16'hA5C3};
        vecs[9]  = '{32, OP_WRITE, 5'd1, 5'd4,  2'b11, 16'h5555, 0, 0, 16'h0000, 8'd2, 5'd4, 16'hA5C3};
        vecs[10] = '{32, OP_READ,  5'd1, 5'd5,  2'b10, 16'h0000, 0, 1, 16'h0000, 8'd2, 5'd4, 16'hA5C3};

        mdc = 1'b1;
        mdio_out = 1'b1;
        mdio_oe = 1'b0;
        rst = 1'b1;
        rst2 = 1'b1;
        #1;
        chk("reset_outputs", {28'b0, mdio_in, mdio_in_oe, wr_strobe, busy}, 32'h8);
        chk("reset_wr", {11'b0, wr_addr, wr_data}, 32'd0);
        chk("reset_err", {24'b0, err_cnt}, 32'd0);
        #99;
        rst = 1'b0;
        #100;
        chk("post_reset_outputs", {28'b0, mdio_in, mdio_in_oe, wr_strobe, busy}, 32'h8);

        foreach (vecs[i]) begin
            sc0 = strobe_cnt;
            run_frame(vecs[i].pre,
                      mk_body(vecs[i].op, vecs[i].phy, vecs[i].ra, vecs[i].ta, vecs[i].wd),
                      mk_oe(vecs[i].op), -1);
            check_frame($sformatf("vec%0d", i), sc0, vecs[i].exp_strobe, vecs[i].exp_drive,
                        vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_wa, vecs[i].exp_wd);
        end

        foreach (mregs[i]) mregs[i] = '0;
        mregs[4] = 16'hA5C3;
        merr = 8'd2;
        mwa = 5'd4;
        mwd = 16'hA5C3;

        for (int n = 0; n < 40; n++) begin
            phy = ($urandom_range(0, 3) == 0) ? 5'd2 : 5'd1;
            op  = ($urandom_range(0, 1) == 0) ? OP_WRITE : OP_READ;
            ra  = 5'($urandom_range(0, 31));
            wd  = 16'($urandom);
            es  = 0;
            ed  = 0;
            erd = '0;
            if (phy == 5'd1 && op == OP_WRITE && ra < NREGS) begin
                mregs[ra] = wd;
                mwa = ra;
                mwd = wd;
                es = 1;
            end
            if (phy == 5'd1 && op == OP_READ) begin
                ed = 1;
                erd = (ra < NREGS) ? mregs[ra] : 16'hFFFF;
            end
            sc0 = strobe_cnt;
            run_frame(32, mk_body(op, phy, ra, 2'b10, wd), mk_oe(op), -1);
            check_frame($sformatf("rnd%0d", n), sc0, es, ed, erd, merr, mwa, mwd);
        end

        // Controller stops driving in the middle of the register address.
        sc0 = strobe_cnt;
        bd = mk_body(OP_WRITE, 5'd1, 5'd3, 2'b10, 16'h7777);
        boe = 32'hFFFF_FFFF;
        boe[31-10] = 1'b0;
        run_frame(32, bd, boe, -1);
        merr = merr + 8'd1;
        check_frame("oe_drop", sc0, 0, 0, 16'h0000, merr, mwa, mwd);

        rst2 = 1'b0;
        #100;
        for (int i = 0; i < 300; i++) begin
            mdio_bit(1'b1, 1'b1, -1, 1'b0);
            mdio_bit(1'b1, 1'b0, -1, 1'b0);
            mdio_bit(1'b1, 1'b0, -1, 1'b0);
            if (i == 253) chk("err_254", {24'b0, d2_err}, 32'd254);
        end
        chk("err_saturated", {24'b0, d2_err}, 32'd255);
        chk("err_main_unchanged", {24'b0, err_cnt}, {24'b0, merr});

        sc0 = strobe_cnt;
        run_frame(32, mk_body(OP_WRITE, 5'd1, 5'd4, 2'b10, 16'hA5C3), mk_oe(OP_WRITE), -1);
        mregs[4] = 16'hA5C3;
        mwa = 5'd4;
        mwd = 16'hA5C3;
        check_frame("rst_setup", sc0, 1, 0, 16'h0000, merr, mwa, mwd);

        run_frame(32, mk_body(OP_READ, 5'd1, 5'd4, 2'b10, 16'h0000), mk_oe(OP_READ), 23);
        foreach (mregs[i]) mregs[i] = '0;
        merr = '0;
        mwa = '0;
        mwd = '0;
        sc0 = strobe_cnt;
        run_frame(32, mk_body(OP_READ, 5'd1, 5'd4, 2'b10, 16'h0000), mk_oe(OP_READ), -1);
        check_frame("after_rst", sc0, 0, 1, mregs[4], merr, mwa, mwd);

        chk("strobe_width", strobe_wide, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
